// File: rtl/convolutional_encoder.sv
// K=7 rate-1/2 convolutional encoder (g0=133, g1=171 octal) with 1/2, 2/3, 3/4 puncturing
// and a 2-entry output FIFO under ready/valid flow control on both sides.
module convolutional_encoder (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Stop,
    input  logic [1:0] Rate,
    input  logic       Input,
    input  logic       InputValid,
    output logic       InputReady,
    output logic       Output,
    output logic       OutputValid,
    input  logic       OutputReady
);

    localparam logic [1:0] RATE_1_2 = 2'd0;
    localparam logic [1:0] RATE_2_3 = 2'd1;
    localparam logic [1:0] RATE_3_4 = 2'd2;

    typedef enum logic [1:0] {IDLE, ENCODE, DRAIN} state_t;

    state_t     state;
    logic [5:0] s;
    logic [1:0] rate_q;
    logic [1:0] phase, phase_n;
    logic [1:0] count, count_n;
    logic [1:0] fifo, fifo_n;   // fifo[0] is the head
    logic       accept, pop;
    logic       coded_a, coded_b;
    logic       push_a, push_b;

    assign OutputValid = (count != 2'd0);
    assign Output      = fifo[0] & OutputValid;
    assign InputReady  = (state == ENCODE) &
                         ((count == 2'd0) | ((count == 2'd1) & OutputReady));
    assign accept      = InputReady & InputValid & ~Start;
    assign pop         = OutputValid & OutputReady;

    assign coded_a = Input ^ s[1] ^ s[2] ^ s[4] ^ s[5];
    assign coded_b = Input ^ s[0] ^ s[1] ^ s[2] ^ s[5];

    always_comb begin
        push_a  = 1'b1;
        push_b  = 1'b1;
        phase_n = 2'd0;
        case (rate_q)
            RATE_2_3: begin
                push_b  = (phase == 2'd0);
                phase_n = (phase == 2'd1) ? 2'd0 : phase + 2'd1;
            end
            RATE_3_4: begin
                push_a  = (phase != 2'd2);
                push_b  = (phase != 2'd1);
                phase_n = (phase == 2'd2) ? 2'd0 : phase + 2'd1;
            end
            default: ;
        endcase
    end

    // An accept only happens when the FIFO is empty after this cycle's pop,
    // so pushed bits always land at the head. Empty slots are kept at zero.
    always_comb begin
        fifo_n  = fifo;
        count_n = count;
        if (pop) begin
            fifo_n  = {1'b0, fifo[1]};
            count_n = count - 2'd1;
        end
        if (accept) begin
            if (push_a && push_b) begin
                fifo_n  = {coded_b, coded_a};
                count_n = 2'd2;
            end else if (push_a) begin
                fifo_n  = {1'b0, coded_a};
                count_n = 2'd1;
            end else begin
                fifo_n  = {1'b0, coded_b};
                count_n = 2'd1;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            s      <= '0;
            phase  <= '0;
            rate_q <= RATE_1_2;
            count  <= '0;
            fifo   <= '0;
        end else if (Start) begin
            state  <= ENCODE;
            s      <= '0;
            phase  <= '0;
            rate_q <= (Rate == 2'b11) ? RATE_1_2 : Rate;
            count  <= '0;
            fifo   <= '0;
        end else begin
            fifo  <= fifo_n;
            count <= count_n;
            if (accept) begin
                s     <= {s[4:0], Input};
                phase <= phase_n;
            end
            case (state)
                ENCODE:  if (Stop) state <= DRAIN;
                DRAIN:   if (count == 2'd0) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/convolutional_encoder.md
CONVOLUTIONAL_ENCODER -- requirements
Module: convolutional_encoder

Interface
REQ-001 SHALL have ports: Clock  in  1  single rising-edge clock for all state.
REQ-002 SHALL have ports: Reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: Start  in  1  active-high one-shot; flushes encoder, latches Rate, enters ENCODE.
REQ-004 SHALL have ports: Stop  in  1  active-high one-shot; ends frame after buffered bits drain.
REQ-005 SHALL have ports: Rate  in  2  code rate, sampled only on Start: 00=1/2, 01=2/3, 10=3/4, 11 treated as 1/2.
REQ-006 SHALL have ports: Input, InputValid  in  1 each  scrambled data bit and its qualifier.
REQ-007 SHALL have ports: InputReady  out  1  encoder can accept a bit this cycle.
REQ-008 SHALL have ports: Output, OutputValid  out  1 each  coded serial bit and its qualifier.
REQ-009 SHALL have ports: OutputReady  in  1  downstream accepts Output this cycle.

Function
REQ-010 SHALL implement K=7 encoder, generators g0=133 (octal), g1=171 (octal), 6-bit state s[5:0], s[0] = most recent previous bit.
REQ-011 SHALL compute A = x^s[1]^s[2]^s[4]^s[5], B = x^s[0]^s[1]^s[2]^s[5]; on accept, s <= {s[4:0], x}.
REQ-012 SHALL accept a bit on a rising edge when InputValid & InputReady; emit a bit when OutputValid & OutputReady.
REQ-013 SHALL hold coded bits in a 2-entry FIFO, A before B; Output/OutputValid driven from FIFO head; OutputValid = (count != 0).
REQ-014 SHALL drive InputReady = ENCODE & ((count==0) | (count==1 & OutputReady)); push and pop in same cycle both take effect.
REQ-015 SHALL puncture per phase counter (cleared on Start): rate 1/2 pushes A,B every bit.
REQ-016 SHALL puncture at rate 2/3 (phase mod 2): phase0 push A,B; phase1 push A only.
REQ-017 SHALL puncture at rate 3/4 (phase mod 3): phase0 push A,B; phase1 push A only; phase2 push B only.
REQ-018 SHALL advance phase only on accepted input bits; phase wraps 1->0 (2/3) or 2->0 (3/4).
REQ-019 SHALL hold Output/OutputValid stable while OutputValid & !OutputReady; no bit dropped or duplicated.
REQ-020 SHALL implement FSM IDLE -> ENCODE (Start) -> DRAIN (Stop) -> IDLE (count==0).
REQ-021 SHALL, in DRAIN, hold InputReady=0 and emit remaining FIFO bits.
REQ-022 SHALL, on Stop coincident with an accepted bit, encode that bit before entering DRAIN.
REQ-023 SHALL give Start priority over Stop and input in any state: clear s, phase, FIFO; latch Rate; enter ENCODE; discard undelivered bits.
REQ-024 SHALL ignore Stop in IDLE and DRAIN, and ignore InputValid outside ENCODE.
REQ-025 SHALL have latency: first coded bit of an accepted input appears on Output the cycle after acceptance.
REQ-026 SHALL sustain full rate with OutputReady held high: rate 1/2 accepts one bit per 2 clocks with no Output gaps.
REQ-027 SHALL not generate tail bits; the upstream stage supplies six zero tail bits.

Reset
REQ-028 SHALL, on Reset, asynchronously set state IDLE, s=0, phase=0, FIFO count=0, latched Rate=00.
REQ-029 SHALL, on Reset, force Output=0, OutputValid=0, InputReady=0 immediately, including mid-frame; first edge after release is IDLE.

Verification
REQ-030 SHALL verify impulse at rate 1/2: Start, Rate=00, input 1,0,0,0,0,0,0, OutputReady=1 -> Output 11 01 11 11 00 10 11.
REQ-031 SHALL verify the same impulse at rate 3/4 -> Output 1101 1100 11 (10 bits).
REQ-032 SHALL verify the same impulse at rate 2/3 -> Output 110 111 001 11 (11 bits).
REQ-033 SHALL verify backpressure: rate 1/2, OutputReady toggled randomly -> same bit sequence as REQ-030; Output stable while stalled; InputReady low while FIFO full.
REQ-034 SHALL verify Start mid-frame with FIFO holding 2 bits -> FIFO cleared; next input 1 yields 11 as if from zero state.
REQ-035 SHALL verify Stop with 2 bits buffered -> both emitted, then IDLE, InputReady=0; Reset pulsed mid-frame -> outputs 0 asynchronously.
